// File: rtl/conv_scan_ctrl.sv
// Scan sequencer for one convolution clause engine. It walks every patch position,
// streams image columns to the datapath, and reduces the clause outputs to OR, count and first hit.
module conv_scan_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = 5,
  parameter int CNT_W = 10,
  parameter int LAT3  = 4,
  parameter int LAT5  = 5,
  parameter int LAT7  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       patch_size_in,
  input  logic             abort,
  output logic             rd_en,
  output logic [CW-1:0]    rd_x,
  output logic [CW-1:0]    rd_y,
  input  logic [6:0]       rd_data,
  output logic [6:0]       pixels,
  output logic [2:0]       patch_size,
  output logic             pe_enable,
  output logic             conv_enable,
  output logic             win_valid,
  output logic [CW-1:0]    win_x,
  output logic [CW-1:0]    win_y,
  input  logic             clause_op,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             clause_any,
  output logic [CNT_W-1:0] hit_count,
  output logic [CW-1:0]    first_x,
  output logic [CW-1:0]    first_y
);

  localparam int LMAX = (LAT3 > LAT5) ? ((LAT3 > LAT7) ? LAT3 : LAT7)
                                      : ((LAT5 > LAT7) ? LAT5 : LAT7);
  localparam int YW   = CW + 4;

  typedef enum logic [1:0] {S_IDLE, S_ROW, S_DRAIN, S_FIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] x, y;
  logic [7:0]    dcnt;
  logic [7:0]    lat;
  logic [2:0]    psz;
  logic          err_q, err_pulse;
  logic          psz_ok, last_col, drain_end, last_band, accept;

  logic          pix_valid;
  logic [CW-1:0] pix_x, pix_y;
  logic          win_ok;
  logic [6:0]    mask;

  logic          dl_v [LMAX];
  logic [CW-1:0] dl_x [LMAX];
  logic [CW-1:0] dl_y [LMAX];
  logic          tap_v;
  logic [CW-1:0] tap_x, tap_y;
  logic          hit;

  always_comb begin
    psz_ok    = (patch_size_in == 3'd3) || (patch_size_in == 3'd5) || (patch_size_in == 3'd7);
    accept    = (state == S_IDLE) && start && psz_ok;
    case (psz)
      3'd3:    lat = 8'(LAT3);
      3'd5:    lat = 8'(LAT5);
      default: lat = 8'(LAT7);
    endcase
    last_col  = (x == CW'(IMG_W - 1));
    drain_end = (dcnt == lat);
    last_band = (YW'(y) + YW'(psz)) >= YW'(IMG_H);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ROW;
      S_ROW: begin
        if (abort)         state_nxt = S_IDLE;
        else if (last_col) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)          state_nxt = S_IDLE;
        else if (drain_end) state_nxt = last_band ? S_FIN : S_ROW;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      dcnt      <= '0;
      psz       <= '0;
      err_q     <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && psz_ok) begin
            psz   <= patch_size_in;
            x     <= '0;
            y     <= '0;
            err_q <= 1'b0;
          end else if (start) begin
            err_q     <= 1'b1;
            err_pulse <= 1'b1;
          end
        end
        S_ROW: begin
          if (abort || last_col) begin
            x    <= '0;
            dcnt <= '0;
          end else begin
            x <= x + 1'b1;
          end
        end
        S_DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (!abort && drain_end && !last_band) y <= y + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pixel stage lags the read by one cycle; it carries the column coordinate forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      pix_valid <= rd_en && !abort;
      pix_x     <= x;
      pix_y     <= y;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 7; i++) mask[i] = (i < 32'(psz));
    win_ok      = pix_valid && ((YW'(pix_x) + YW'(1)) >= YW'(psz));
    win_valid   = win_ok;
    win_x       = win_ok ? CW'(YW'(pix_x) + YW'(1) - YW'(psz)) : '0;
    win_y       = win_ok ? pix_y : '0;
    pixels      = pix_valid ? (rd_data & mask) : '0;
    pe_enable   = pix_valid || (state == S_DRAIN);
    rd_en       = (state == S_ROW);
    rd_x        = x;
    rd_y        = y;
    busy        = (state == S_ROW) || (state == S_DRAIN);
    conv_enable = busy;
    done        = (state == S_FIN) || err_pulse;
    err         = err_q;
    patch_size  = psz;
  end

  // Delay line sized for the longest latency; the tap follows the latched patch size
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LMAX; i++) begin
        dl_v[i] <= 1'b0;
        dl_x[i] <= '0;
        dl_y[i] <= '0;
      end
    end else if (abort && (state != S_IDLE)) begin
      for (int unsigned i = 0; i < LMAX; i++) dl_v[i] <= 1'b0;
    end else begin
      dl_v[0] <= win_valid;
      dl_x[0] <= win_x;
      dl_y[0] <= win_y;
      for (int unsigned i = 1; i < LMAX; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_x[i] <= dl_x[i-1];
        dl_y[i] <= dl_y[i-1];
      end
    end
  end

  always_comb begin
    tap_v = 1'b0;
    tap_x = '0;
    tap_y = '0;
    for (int unsigned i = 0; i < LMAX; i++) begin
      if ((i + 1) == 32'(lat)) begin
        tap_v = dl_v[i];
        tap_x = dl_x[i];
        tap_y = dl_y[i];
      end
    end
    hit = tap_v && clause_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clause_any <= 1'b0;
      hit_count  <= '0;
      first_x    <= '0;
      first_y    <= '0;
    end else if (accept) begin
      clause_any <= 1'b0;
      hit_count  <= '0;
      first_x    <= '0;
      first_y    <= '0;
    end else if (hit) begin
      clause_any <= 1'b1;
      if (hit_count != '1) hit_count <= hit_count + 1'b1;
      if (!clause_any) begin
        first_x <= tap_x;
        first_y <= tap_y;
      end
    end
  end

endmodule
